// File: rtl/uart_pixel_packer_if.sv
// Byte-in / RAM-port-A-out bundle for the UART pixel packer.
// The master side feeds bytes and watches the RAM port; the slave side is the packer.
interface uart_pixel_packer_if;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        ram_ena;
  logic        ram_wea;
  logic [15:0] ram_addra;
  logic [15:0] ram_dina;
  logic        frame_done;
  logic        err_timeout;

  modport master (
    output rx_data, rx_done,
    input  ram_ena, ram_wea, ram_addra, ram_dina, frame_done, err_timeout
  );

  modport slave (
    input  rx_data, rx_done,
    output ram_ena, ram_wea, ram_addra, ram_dina, frame_done, err_timeout
  );
endinterface

// File: rtl/uart_pixel_packer.sv
// Pairs UART bytes into RGB565 pixels (high byte first) and writes them to
// sequential frame-buffer addresses; an inter-byte timeout drops a half pixel.
module uart_pixel_packer #(
  parameter int H_DISP      = 200,
  parameter int V_DISP      = 200,
  parameter int TIMEOUT_CYC = 5000000,
  parameter int RESYNC_ADDR = 1
) (
  input  logic                Clk,
  input  logic                Reset_n,
  uart_pixel_packer_if.slave  bus
);

  localparam int              FRAME_PIXELS = H_DISP * V_DISP;
  localparam logic [15:0]     LAST_ADDR    = 16'(FRAME_PIXELS - 1);
  localparam int              CNT_W        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_HI = 2'd0,
    S_LO = 2'd1,
    S_WR = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_hi;
  logic [15:0]      r_addr;
  logic [15:0]      r_dina;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic w_latch_hi;
  logic w_load_pix;
  logic w_cnt_inc;
  logic w_timeout;
  logic w_wr;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_HI;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_latch_hi  = 1'b0;
    w_load_pix  = 1'b0;
    w_cnt_inc   = 1'b0;
    w_timeout   = 1'b0;
    w_wr        = 1'b0;
    unique case (r_state)
      S_HI: begin
        if (bus.rx_done) begin
          w_latch_hi  = 1'b1;
          w_state_nxt = S_LO;
        end
      end
      S_LO: begin
        if (bus.rx_done) begin
          w_load_pix  = 1'b1;
          w_state_nxt = S_WR;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_HI;
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end
      S_WR: begin
        w_wr = 1'b1;
        // A byte arriving during the write cycle is the next high byte.
        if (bus.rx_done) begin
          w_latch_hi  = 1'b1;
          w_state_nxt = S_LO;
        end else begin
          w_state_nxt = S_HI;
        end
      end
      default: w_state_nxt = S_HI;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hi   <= '0;
      r_addr <= '0;
      r_dina <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_timeout;

      if (w_latch_hi)     r_hi <= bus.rx_data;
      else if (w_timeout) r_hi <= '0;

      if (w_load_pix) r_dina <= {r_hi, bus.rx_data};

      // Counter only runs while a half pixel is pending; it sits at zero otherwise.
      if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
      else           r_cnt <= '0;

      if (w_wr) begin
        r_addr <= (r_addr == LAST_ADDR) ? 16'd0 : r_addr + 16'd1;
      end else if (w_timeout && (RESYNC_ADDR != 0)) begin
        r_addr <= '0;
      end
    end
  end

  assign bus.ram_ena     = w_wr;
  assign bus.ram_wea     = w_wr;
  assign bus.ram_addra   = r_addr;
  assign bus.ram_dina    = r_dina;
  assign bus.frame_done  = w_wr && (r_addr == LAST_ADDR);
  assign bus.err_timeout = r_err;

endmodule

// File: tb/tb_uart_pixel_packer.sv
// Bench for uart_pixel_packer: a byte-pairing model predicts the RAM port each
// cycle, and directed scenarios pin both the model and the DUT with literals.
module tb_uart_pixel_packer;

  localparam int H_DISP  = 10;
  localparam int V_DISP  = 4;
  localparam int FRAME   = H_DISP * V_DISP;
  localparam int TIMEOUT = 16;
  localparam int RESYNC  = 1;

  logic Clk;
  logic Reset_n;

  uart_pixel_packer_if bus ();

  uart_pixel_packer #(
    .H_DISP      (H_DISP),
    .V_DISP      (V_DISP),
    .TIMEOUT_CYC (TIMEOUT),
    .RESYNC_ADDR (RESYNC)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel-level view: a pending high byte, how long it has waited, and where
  // the write pointer is; exp_* describe what the port must show this cycle.
  typedef struct {
    bit          pending;
    logic [7:0]  hi;
    int          idle;
    int          addr;
    bit          exp_wea;
    logic [15:0] exp_data;
    bit          exp_fd;
    bit          exp_err;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.pending  = 1'b0;
    r.hi       = 8'h00;
    r.idle     = 0;
    r.addr     = 0;
    r.exp_wea  = 1'b0;
    r.exp_data = 16'h0000;
    r.exp_fd   = 1'b0;
    r.exp_err  = 1'b0;
    return r;
  endfunction

  function automatic model_t step(model_t cur, logic done, logic [7:0] d);
    model_t n;
    n         = cur;
    n.exp_wea = 1'b0;
    n.exp_fd  = 1'b0;
    n.exp_err = 1'b0;
    if (cur.exp_wea) n.addr = (cur.addr + 1) % FRAME;
    if (done) begin
      if (!cur.pending) begin
        n.pending = 1'b1;
        n.hi      = d;
        n.idle    = 0;
      end else begin
        n.pending  = 1'b0;
        n.exp_wea  = 1'b1;
        n.exp_data = {cur.hi, d};
        n.exp_fd   = (n.addr == FRAME - 1);
      end
    end else if (cur.pending) begin
      n.idle = cur.idle + 1;
      if (n.idle == TIMEOUT) begin
        n.pending = 1'b0;
        n.exp_err = 1'b1;
        if (RESYNC != 0) n.addr = 0;
      end
    end
    return n;
  endfunction

  initial begin
    m = model_reset();
    forever begin
      @(posedge Clk or negedge Reset_n);
      if (!Reset_n) m = model_reset();
      else          m = step(m, bus.rx_done, bus.rx_data);
    end
  end

  // Observation log used by the directed literal checks.
  int          wr_count  = 0;
  int          fd_count  = 0;
  int          err_count = 0;
  logic [15:0] last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;
  logic [15:0] fd_addr      = '0;

  initial begin
    forever begin
      @(negedge Clk);
      if (Reset_n) begin
        check("ram_wea",     32'(bus.ram_wea),     32'(m.exp_wea));
        check("ram_ena",     32'(bus.ram_ena),     32'(m.exp_wea));
        check("ram_addra",   32'(bus.ram_addra),   32'(m.addr));
        check("frame_done",  32'(bus.frame_done),  32'(m.exp_fd));
        check("err_timeout", 32'(bus.err_timeout), 32'(m.exp_err));
        if (m.exp_wea) check("ram_dina", 32'(bus.ram_dina), 32'(m.exp_data));
        if (bus.ram_wea) begin
          wr_count++;
          last_wr_addr = bus.ram_addra;
          last_wr_data = bus.ram_dina;
        end
        if (bus.frame_done) begin
          fd_count++;
          fd_addr = bus.ram_addra;
        end
        if (bus.err_timeout) err_count++;
      end
    end
  end

  task automatic send_seq(input logic [7:0] b[$]);
    foreach (b[i]) begin
      @(negedge Clk);
      bus.rx_data = b[i];
      bus.rx_done = 1'b1;
    end
    @(negedge Clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge Clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    @(posedge Clk);
    #3 Reset_n = 1'b1;
  endtask

  int w0, e0, f0;

  initial begin
    logic [7:0] stream[$];
    Reset_n     = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;

    repeat (3) @(posedge Clk);
    #2;
    check("rst_ena",   32'(bus.ram_ena),     32'd0);
    check("rst_wea",   32'(bus.ram_wea),     32'd0);
    check("rst_addr",  32'(bus.ram_addra),   32'd0);
    check("rst_dina",  32'(bus.ram_dina),    32'd0);
    check("rst_fd",    32'(bus.frame_done),  32'd0);
    check("rst_err",   32'(bus.err_timeout), 32'd0);
    #1 Reset_n = 1'b1;

    // First pixel
    send_seq('{8'hF8, 8'h00});
    settle();
    check("first_wr_count", 32'(wr_count),     32'd1);
    check("first_wr_data",  32'(last_wr_data), 32'hF800);
    check("first_wr_addr",  32'(last_wr_addr), 32'd0);
    check("first_addr_nxt", 32'(bus.ram_addra), 32'd1);
    check("first_wea_low",  32'(bus.ram_wea),   32'd0);
    check("model_addr",     32'(m.addr),        32'd1);
    check("model_data",     32'(m.exp_data),    32'hF800);

    // Timeout with address resync
    e0 = err_count;
    send_seq('{8'hAB});
    repeat (TIMEOUT + 4) @(negedge Clk);
    settle();
    check("to_err_count", 32'(err_count - e0), 32'd1);
    check("to_addr",      32'(bus.ram_addra),  32'd0);
    send_seq('{8'h12, 8'h34});
    settle();
    check("to_next_data", 32'(last_wr_data), 32'h1234);
    check("to_next_addr", 32'(last_wr_addr), 32'd0);

    // One idle cycle short of the timeout: pixel survives
    e0 = err_count;
    send_seq('{8'hC1});
    repeat (TIMEOUT - 2) @(negedge Clk);
    send_seq('{8'hC2});
    settle();
    check("edge_no_err",  32'(err_count - e0), 32'd0);
    check("edge_data",    32'(last_wr_data),   32'hC1C2);
    check("edge_addr",    32'(last_wr_addr),   32'd1);

    // Exactly at the timeout: D1 dropped, D2 becomes the high byte
    send_seq('{8'hD1});
    repeat (TIMEOUT - 1) @(negedge Clk);
    send_seq('{8'hD2});
    send_seq('{8'hD3});
    settle();
    check("edge_err",      32'(err_count - e0), 32'd1);
    check("edge_to_data",  32'(last_wr_data),   32'hD2D3);
    check("edge_to_addr",  32'(last_wr_addr),   32'd0);

    // Full frame plus one pixel, bytes back to back
    do_reset();
    w0 = wr_count;
    f0 = fd_count;
    stream.delete();
    for (int n = 0; n <= FRAME; n++) begin
      stream.push_back(8'(n) ^ 8'h5A);
      stream.push_back(8'(n));
    end
    send_seq(stream);
    settle();
    check("frame_writes",   32'(wr_count - w0), 32'd41);
    check("frame_fd_count", 32'(fd_count - f0), 32'd1);
    check("frame_fd_addr",  32'(fd_addr),       32'd39);
    check("frame_wrap_addr", 32'(last_wr_addr), 32'd0);
    check("frame_wrap_data", 32'(last_wr_data), 32'h7228);
    check("frame_addr_nxt", 32'(bus.ram_addra), 32'd1);

    // High byte arriving on the write cycle
    do_reset();
    send_seq('{8'h11, 8'h22, 8'h55, 8'h66});
    settle();
    check("wr_cycle_data", 32'(last_wr_data), 32'h5566);
    check("wr_cycle_addr", 32'(last_wr_addr), 32'd1);

    // Reset between high and low byte
    w0 = wr_count;
    send_seq('{8'h77});
    do_reset();
    send_seq('{8'h01, 8'h02});
    settle();
    check("mid_rst_writes", 32'(wr_count - w0), 32'd1);
    check("mid_rst_data",   32'(last_wr_data),  32'h0102);
    check("mid_rst_addr",   32'(last_wr_addr),  32'd0);

    // Reset during the write cycle: strobe vanishes at once
    w0 = wr_count;
    send_seq('{8'hAA});
    @(negedge Clk);
    bus.rx_data = 8'hBB;
    bus.rx_done = 1'b1;
    @(posedge Clk);
    #1 Reset_n = 1'b0;
    bus.rx_done = 1'b0;
    #1;
    check("wr_rst_wea",  32'(bus.ram_wea),   32'd0);
    check("wr_rst_addr", 32'(bus.ram_addra), 32'd0);
    check("wr_rst_dina", 32'(bus.ram_dina),  32'd0);
    @(posedge Clk);
    #3 Reset_n = 1'b1;
    settle();
    check("wr_rst_writes", 32'(wr_count - w0), 32'd0);

    repeat (3) @(posedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
